// File: rtl/demux_1x4_stream_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
// Imported by the interface, the slot and the top.
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/demux_1x4_stream_if.sv
// Bundle of the input stream and the four output channels.
// slave: the demux side; master: the upstream/downstream side.
interface demux_1x4_stream_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic [DATA_W-1:0] out_data2;
  logic [DATA_W-1:0] out_data3;
  logic              out_valid0;
  logic              out_valid1;
  logic              out_valid2;
  logic              out_valid3;
  logic              out_ready0;
  logic              out_ready1;
  logic              out_ready2;
  logic              out_ready3;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic [CNT_W-1:0]  cnt2;
  logic [CNT_W-1:0]  cnt3;

  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output out_data0, out_data1, out_data2, out_data3,
    output out_valid0, out_valid1, out_valid2, out_valid3,
    input  out_ready0, out_ready1, out_ready2, out_ready3,
    output cnt0, cnt1, cnt2, cnt3
  );

  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  out_data0, out_data1, out_data2, out_data3,
    input  out_valid0, out_valid1, out_valid2, out_valid3,
    output out_ready0, out_ready1, out_ready2, out_ready3,
    input  cnt0, cnt1, cnt2, cnt3
  );
endinterface

// File: rtl/demux_1x4_stream_slot.sv
// One output channel: single-entry holding slot, EMPTY/FULL FSM
// and a saturating delivery counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt,
  output logic              can_load
);
  slot_state_t state;
  slot_state_t state_nxt;
  logic        xfer;

  assign out_valid = (state == SLOT_FULL);
  assign xfer      = out_valid && out_ready;
  assign can_load  = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A load in the same cycle as a drain keeps the slot full.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (xfer && !load) state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (xfer && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demux: routes each input word by
// in_sel into one of four independently drained holding slots.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  demux_1x4_stream_if.slave bus
);
  logic [N_CH-1:0]   load;
  logic [N_CH-1:0]   can_load;
  logic [N_CH-1:0]   ready;
  logic [N_CH-1:0]   valid;
  logic [DATA_W-1:0] data [N_CH];
  logic [CNT_W-1:0]  cnt  [N_CH];

  assign ready = {bus.out_ready3, bus.out_ready2,
                  bus.out_ready1, bus.out_ready0};

  // Depends only on the selected slot, never on in_valid.
  assign bus.in_ready = can_load[bus.in_sel];

  always_comb begin
    load = '0;
    if (bus.in_valid && bus.in_ready) begin
      unique case (1'b1)
        bus.in_sel == 2'd0: load[0] = 1'b1;
        bus.in_sel == 2'd1: load[1] = 1'b1;
        bus.in_sel == 2'd2: load[2] = 1'b1;
        bus.in_sel == 2'd3: load[3] = 1'b1;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (bus.in_data),
      .out_data  (data[i]),
      .out_valid (valid[i]),
      .out_ready (ready[i]),
      .cnt       (cnt[i]),
      .can_load  (can_load[i])
    );
  end

  assign bus.out_data0  = data[0];
  assign bus.out_data1  = data[1];
  assign bus.out_data2  = data[2];
  assign bus.out_data3  = data[3];
  assign bus.out_valid0 = valid[0];
  assign bus.out_valid1 = valid[1];
  assign bus.out_valid2 = valid[2];
  assign bus.out_valid3 = valid[3];
  assign bus.cnt0       = cnt[0];
  assign bus.cnt1       = cnt[1];
  assign bus.cnt2       = cnt[2];
  assign bus.cnt3       = cnt[3];
endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed bench for demux_1x4_stream with 4-bit counters so
// saturation is reachable in a short run.
module tb_demux_1x4_stream;
  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  demux_1x4_stream_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  demux_1x4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [3:0]    vld;
  logic [3:0]    rdy;
  logic [DW-1:0] dat [4];
  logic [CW-1:0] cn  [4];
  assign vld = {bus.out_valid3, bus.out_valid2,
                bus.out_valid1, bus.out_valid0};
  assign rdy = {bus.out_ready3, bus.out_ready2,
                bus.out_ready1, bus.out_ready0};
  assign dat[0] = bus.out_data0;
  assign dat[1] = bus.out_data1;
  assign dat[2] = bus.out_data2;
  assign dat[3] = bus.out_data3;
  assign cn[0]  = bus.cnt0;
  assign cn[1]  = bus.cnt1;
  assign cn[2]  = bus.cnt2;
  assign cn[3]  = bus.cnt3;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Snapshot taken at the previous rising edge, before state updates.
  logic [3:0]    pv  = '0;
  logic [3:0]    pr  = '0;
  logic [DW-1:0] pd [4];
  logic          piv = 1'b0;
  logic          pir = 1'b0;
  logic [1:0]    ps  = '0;
  logic [DW-1:0] pdi = '0;

  // Advance one cycle; at the edge check slot stability under stall
  // and that the upstream held a refused word.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int n = 0; n < 4; n++) begin
        if (pv[n] && !pr[n]) begin
          chk($sformatf("stall_valid%0d", n), 32'(vld[n]), 1);
          chk($sformatf("stall_data%0d", n), 32'(dat[n]), 32'(pd[n]));
        end
      end
      if (piv && !pir) begin
        chk("hold_valid", 32'(bus.in_valid), 1);
        chk("hold_sel", 32'(bus.in_sel), 32'(ps));
        chk("hold_data", 32'(bus.in_data), 32'(pdi));
      end
    end
    pv  = rst_n ? vld : 4'b0;
    pr  = rdy;
    for (int n = 0; n < 4; n++) pd[n] = dat[n];
    piv = rst_n && bus.in_valid;
    pir = bus.in_ready;
    ps  = bus.in_sel;
    pdi = bus.in_data;
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_data    = '0;
    bus.in_sel     = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready0 = 1'b0;
    bus.out_ready1 = 1'b0;
    bus.out_ready2 = 1'b0;
    bus.out_ready3 = 1'b0;
    tick();

    // Reset state
    chk("rst_vld", 32'(vld), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("rst_data%0d", n), 32'(dat[n]), 0);
      chk($sformatf("rst_cnt%0d", n), 32'(cn[n]), 0);
    end
    rst_n = 1'b1;
    tick();

    // 1. Single route to channel 2
    bus.in_sel     = 2'd2;
    bus.in_data    = 8'hA5;
    bus.in_valid   = 1'b1;
    bus.out_ready2 = 1'b1;
    #1;
    chk("t1_in_ready", 32'(bus.in_ready), 1);
    chk("t1_vld2_before", 32'(vld[2]), 0);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_vld", 32'(vld), 32'h4);
    chk("t1_data2", 32'(dat[2]), 32'hA5);
    chk("t1_cnt2_pre", 32'(cn[2]), 0);
    tick();
    chk("t1_cnt2", 32'(cn[2]), 1);
    chk("t1_vld_after", 32'(vld), 0);
    chk("t1_data2_hold", 32'(dat[2]), 32'hA5);
    chk("t1_cnt0", 32'(cn[0]), 0);
    chk("t1_cnt1", 32'(cn[1]), 0);
    chk("t1_cnt3", 32'(cn[3]), 0);
    bus.out_ready2 = 1'b0;

    // 2. Eight back-to-back words to channel 1
    bus.out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_sel   = 2'd1;
      bus.in_data  = 8'(8'h10 + i);
      bus.in_valid = 1'b1;
      #1;
      chk($sformatf("t2_in_ready%0d", i), 32'(bus.in_ready), 1);
      if (i > 0) begin
        chk($sformatf("t2_data%0d", i), 32'(dat[1]), 32'(8'h10 + i - 1));
        chk($sformatf("t2_vld%0d", i), 32'(vld[1]), 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t2_data_last", 32'(dat[1]), 32'h17);
    chk("t2_vld_last", 32'(vld[1]), 1);
    chk("t2_cnt1_pre", 32'(cn[1]), 7);
    tick();
    chk("t2_cnt1", 32'(cn[1]), 8);
    chk("t2_vld1_empty", 32'(vld[1]), 0);
    bus.out_ready1 = 1'b0;

    // 3. Stall on channel 0 blocks only words for channel 0
    bus.in_sel   = 2'd0;
    bus.in_data  = 8'h11;
    bus.in_valid = 1'b1;
    #1;
    chk("t3_in_ready_a", 32'(bus.in_ready), 1);
    tick();
    bus.in_data = 8'h22;
    #1;
    chk("t3_stall_ready", 32'(bus.in_ready), 0);
    chk("t3_vld0", 32'(vld[0]), 1);
    chk("t3_data0", 32'(dat[0]), 32'h11);
    tick();
    chk("t3_stall_ready2", 32'(bus.in_ready), 0);
    chk("t3_data0_stable", 32'(dat[0]), 32'h11);
    chk("t3_vld3_blocked", 32'(vld[3]), 0);
    tick();
    bus.out_ready0 = 1'b1;
    #1;
    chk("t3_ready_passthru", 32'(bus.in_ready), 1);
    tick();
    chk("t3_vld0_refill", 32'(vld[0]), 1);
    chk("t3_data0_22", 32'(dat[0]), 32'h22);
    chk("t3_cnt0_1", 32'(cn[0]), 1);
    chk("t3_vld3_still", 32'(vld[3]), 0);
    bus.in_sel  = 2'd3;
    bus.in_data = 8'h33;
    #1;
    chk("t3_in_ready_33", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid   = 1'b0;
    bus.out_ready0 = 1'b0;
    chk("t3_vld0_empty", 32'(vld[0]), 0);
    chk("t3_cnt0_2", 32'(cn[0]), 2);
    chk("t3_data0_keep", 32'(dat[0]), 32'h22);
    chk("t3_vld3", 32'(vld[3]), 1);
    chk("t3_data3", 32'(dat[3]), 32'h33);

    // 4. Drain and refill channel 3 in the same cycle
    bus.out_ready3 = 1'b1;
    bus.in_sel     = 2'd3;
    bus.in_data    = 8'h44;
    bus.in_valid   = 1'b1;
    #1;
    chk("t4_in_ready_44", 32'(bus.in_ready), 1);
    tick();
    chk("t4_data3_44", 32'(dat[3]), 32'h44);
    chk("t4_cnt3_1", 32'(cn[3]), 1);
    bus.in_data = 8'h55;
    #1;
    chk("t4_in_ready_55", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid   = 1'b0;
    bus.out_ready3 = 1'b0;
    chk("t4_vld3", 32'(vld[3]), 1);
    chk("t4_data3_55", 32'(dat[3]), 32'h55);
    chk("t4_cnt3_2", 32'(cn[3]), 2);

    // 5. Counter saturation on channel 0 (starts at 2)
    bus.out_ready0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_sel   = 2'd0;
      bus.in_data  = 8'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t5_cnt0_sat", 32'(cn[0]), 15);
    chk("t5_vld0", 32'(vld[0]), 0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t5_cnt0_hold", 32'(cn[0]), 15);
    chk("t5_cnt3_other", 32'(cn[3]), 2);
    bus.out_ready0 = 1'b0;

    // 6. Asynchronous reset with slots 0 and 1 full
    bus.in_sel   = 2'd0;
    bus.in_data  = 8'h66;
    bus.in_valid = 1'b1;
    tick();
    bus.in_sel  = 2'd1;
    bus.in_data = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    chk("t6_vld_pre", 32'(vld), 32'hB);
    chk("t6_data0_pre", 32'(dat[0]), 32'h66);
    chk("t6_data1_pre", 32'(dat[1]), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_vld_async", 32'(vld), 0);
    chk("t6_data0_async", 32'(dat[0]), 0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("t6_cnt%0d_async", n), 32'(cn[n]), 0);
    end
    chk("t6_in_ready_rst", 32'(bus.in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_in_ready_rel", 32'(bus.in_ready), 1);
    chk("t6_vld_rel", 32'(vld), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
